// File: rtl/axis_uart_tx_arbiter.sv
// axis_uart_tx_arbiter
//   Round-robin, packet-locked arbiter sharing one AXI-Stream byte sink
//   (the UART transmitter) among N_SRC requesters. A grant is held until
//   the granted source's tlast beat is accepted, or force-released when
//   the granted source leaves tvalid low for TIMEOUT_CYCLES cycles.
//
// Ports
//   clk_i, rst_i      clock, synchronous active-high reset
//   s_tdata_i         N_SRC packed source bytes, source k at [k*DATA_WIDTH +: DATA_WIDTH]
//   s_tvalid_i        per-source valid
//   s_tlast_i         per-source end-of-packet
//   s_tready_o        per-source ready (only the granted source sees m_tready_i)
//   m_tdata_o         muxed data to UART TX (0 when idle)
//   m_tvalid_o        muxed valid to UART TX
//   m_tlast_o         muxed end-of-packet to UART TX
//   m_tready_i        ready from UART TX
//   grant_o           one-hot current grant, 0 when idle
//   busy_o            high while a grant is held
//   timeout_o         one-cycle pulse on a forced release
//   timeout_src_o     index of the most recently timed-out source

// Per-source gating: everything from a non-granted source is forced to 0
// so the top level can OR-reduce the lanes into the master stream.
module axis_uart_tx_arbiter_lane #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  gnt,
   input  logic [DATA_WIDTH-1:0] s_tdata,
   input  logic                  s_tvalid,
   input  logic                  s_tlast,
   input  logic                  m_tready,
   output logic [DATA_WIDTH-1:0] sel_tdata,
   output logic                  sel_tvalid,
   output logic                  sel_tlast,
   output logic                  s_tready
);
   assign sel_tdata  = gnt ? s_tdata : '0;
   assign sel_tvalid = gnt & s_tvalid;
   assign sel_tlast  = gnt & s_tlast;
   assign s_tready   = gnt & m_tready;
endmodule

module axis_uart_tx_arbiter #(
   parameter int N_SRC          = 4,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [N_SRC*DATA_WIDTH-1:0] s_tdata_i,
   input  logic [N_SRC-1:0]            s_tvalid_i,
   input  logic [N_SRC-1:0]            s_tlast_i,
   output logic [N_SRC-1:0]            s_tready_o,
   output logic [DATA_WIDTH-1:0]       m_tdata_o,
   output logic                        m_tvalid_o,
   output logic                        m_tlast_o,
   input  logic                        m_tready_i,
   output logic [N_SRC-1:0]            grant_o,
   output logic                        busy_o,
   output logic                        timeout_o,
   output logic [$clog2(N_SRC)-1:0]    timeout_src_o
);
   localparam int IW = $clog2(N_SRC);
   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   typedef enum logic {IDLE, XFER} state_t;

   state_t          state;
   logic [IW-1:0]   last_grant;   // also the index of the current grant while in XFER
   logic [CW-1:0]   to_cnt;
   logic            to_hit;
   logic            hs_last;
   logic [IW-1:0]   pick_idx;
   logic            pick_found;

   logic [N_SRC-1:0][DATA_WIDTH-1:0] sel_tdata;
   logic [N_SRC-1:0]                 sel_tvalid;
   logic [N_SRC-1:0]                 sel_tlast;

   // Forward and ready paths: purely combinational from the registered grant
   for (genvar g = 0; g < N_SRC; g++) begin : g_lane
      axis_uart_tx_arbiter_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
         .gnt       (grant_o[g]),
         .s_tdata   (s_tdata_i[g*DATA_WIDTH +: DATA_WIDTH]),
         .s_tvalid  (s_tvalid_i[g]),
         .s_tlast   (s_tlast_i[g]),
         .m_tready  (m_tready_i),
         .sel_tdata (sel_tdata[g]),
         .sel_tvalid(sel_tvalid[g]),
         .sel_tlast (sel_tlast[g]),
         .s_tready  (s_tready_o[g])
      );
   end

   always_comb begin
      m_tdata_o = '0;
      for (int k = 0; k < N_SRC; k++) m_tdata_o = m_tdata_o | sel_tdata[k];
   end

   assign m_tvalid_o = |sel_tvalid;
   assign m_tlast_o  = |sel_tlast;
   assign hs_last    = m_tvalid_o & m_tready_i & m_tlast_o;
   assign busy_o     = (state == XFER);

   // Rotating priority: first requester strictly after last_grant, wrapping,
   // so the previous owner is considered last.
   always_comb begin
      int cand;
      cand       = 0;
      pick_idx   = last_grant;
      pick_found = 1'b0;
      for (int i = 1; i <= N_SRC; i++) begin
         cand = (int'(last_grant) + i) % N_SRC;
         if (!pick_found && s_tvalid_i[cand]) begin
            pick_found = 1'b1;
            pick_idx   = IW'(cand);
         end
      end
   end

   // to_cnt holds the number of completed low-tvalid cycles, so the release
   // happens on the edge that ends the TIMEOUT_CYCLES-th such cycle.
   if (TIMEOUT_CYCLES > 0) begin : g_to
      assign to_hit = (state == XFER) && !m_tvalid_o &&
                      (to_cnt == CW'(TIMEOUT_CYCLES - 1));
   end else begin : g_no_to
      assign to_hit = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= IDLE;
         grant_o       <= '0;
         last_grant    <= IW'(N_SRC - 1);
         to_cnt        <= '0;
         timeout_o     <= 1'b0;
         timeout_src_o <= '0;
      end else begin
         timeout_o <= 1'b0;
         case (state)
            IDLE: begin
               to_cnt <= '0;
               if (pick_found) begin
                  grant_o    <= N_SRC'(1) << pick_idx;
                  last_grant <= pick_idx;
                  state      <= XFER;
               end
            end
            XFER: begin
               if (hs_last) begin
                  grant_o <= '0;
                  state   <= IDLE;
               end else if (to_hit) begin
                  grant_o       <= '0;
                  state         <= IDLE;
                  timeout_o     <= 1'b1;
                  timeout_src_o <= last_grant;
               end else if (m_tvalid_o) begin
                  // backpressure with valid high never counts
                  to_cnt <= '0;
               end else begin
                  to_cnt <= to_cnt + CW'(1);
               end
            end
            default: begin
               grant_o <= '0;
               state   <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_axis_uart_tx_arbiter.sv
// Bench for axis_uart_tx_arbiter: table vectors for a single packet,
// hand-written multi-cycle corner cases, and a long randomized run checked
// cycle by cycle against a transaction-level reference model.
module tb_axis_uart_tx_arbiter;
   localparam int N  = 4;
   localparam int DW = 8;
   localparam int TO = 8;
   localparam int IW = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [N*DW-1:0]   s_tdata;
   logic [N-1:0]      s_tvalid, s_tlast, s_tready;
   logic [DW-1:0]     m_tdata;
   logic              m_tvalid, m_tlast, m_tready;
   logic [N-1:0]      grant;
   logic              busy, tmo;
   logic [IW-1:0]     tmo_src;

   always #5 clk = ~clk;

   axis_uart_tx_arbiter #(.N_SRC(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk_i(clk), .rst_i(rst),
      .s_tdata_i(s_tdata), .s_tvalid_i(s_tvalid), .s_tlast_i(s_tlast),
      .s_tready_o(s_tready),
      .m_tdata_o(m_tdata), .m_tvalid_o(m_tvalid), .m_tlast_o(m_tlast),
      .m_tready_i(m_tready),
      .grant_o(grant), .busy_o(busy), .timeout_o(tmo), .timeout_src_o(tmo_src)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   int  md_g     = -1;    // granted source, -1 when idle
   int  md_last  = N - 1; // previous owner, searched last
   int  md_low   = 0;     // consecutive low-valid cycles of the owner
   bit  md_to    = 0;
   int  md_tosrc = 0;
   bit  model_on = 0;

   // samples taken once per cycle, away from the clock edge
   logic [N-1:0]  sm_grant, sm_rdy, sm_acc;
   logic          sm_v, sm_l, sm_busy, sm_to, sm_mhs;
   logic [DW-1:0] sm_d;
   logic [IW-1:0] sm_tosrc;

   task automatic model_check();
      logic [N-1:0]  eg, er;
      logic          ev, el;
      logic [DW-1:0] ed;
      eg = '0; er = '0; ev = 1'b0; el = 1'b0; ed = '0;
      if (md_g >= 0) begin
         eg[md_g] = 1'b1;
         ev = s_tvalid[md_g];
         el = s_tlast[md_g];
         ed = s_tdata[md_g*DW +: DW];
         if (m_tready) er[md_g] = 1'b1;
      end
      chk("m_grant",   sm_grant, eg);
      chk("m_tvalid",  sm_v, ev);
      chk("m_tdata",   sm_d, ed);
      chk("m_tlast",   sm_l, el);
      chk("m_sready",  sm_rdy, er);
      chk("m_busy",    sm_busy, (md_g >= 0));
      chk("m_timeout", sm_to, md_to);
      chk("m_tosrc",   sm_tosrc, md_tosrc);
   endtask

   task automatic model_next();
      if (rst) begin
         md_g = -1; md_last = N - 1; md_low = 0; md_to = 0; md_tosrc = 0;
         return;
      end
      md_to = 0;
      if (md_g < 0) begin
         for (int i = 1; i <= N; i++) begin
            if (s_tvalid[(md_last + i) % N]) begin
               md_g    = (md_last + i) % N;
               md_last = md_g;
               md_low  = 0;
               break;
            end
         end
      end else if (s_tvalid[md_g] && m_tready && s_tlast[md_g]) begin
         md_g = -1;
      end else if (!s_tvalid[md_g]) begin
         md_low++;
         if (md_low == TO) begin
            md_to    = 1;
            md_tosrc = md_g;
            md_g     = -1;
         end
      end else begin
         md_low = 0;
      end
   endtask

   // One cycle: inputs already set just after a negedge.
   task automatic step();
      #1;
      sm_grant = grant;  sm_v = m_tvalid; sm_d = m_tdata; sm_l = m_tlast;
      sm_rdy = s_tready; sm_busy = busy;  sm_to = tmo;    sm_tosrc = tmo_src;
      sm_acc = s_tvalid & s_tready;
      sm_mhs = m_tvalid & m_tready;
      if (model_on) model_check();
      model_next();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic set_src(input int k, input logic v, input logic [DW-1:0] d, input logic l);
      s_tvalid[k] = v;
      s_tdata[k*DW +: DW] = d;
      s_tlast[k] = l;
   endtask

   typedef struct packed {
      logic [3:0] vld; logic [7:0] d; logic l; logic rdy;
      logic [3:0] eg;  logic ev; logic [7:0] ed; logic el; logic [3:0] er; logic eb;
   } vec_t;

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vec_t         vt [6];
      logic [DW-1:0] dq[$];
      logic          lq[$];
      int            gq[$];
      int            cnt [N];
      int            gap [N];
      logic [N-1:0]  prev_g;
      logic [N-1:0]  gr [0:15];
      logic          to_a [0:15];
      logic          r0 [0:15];
      logic [IW-1:0] ts [0:15];
      logic [DW-1:0] exp2 [10];
      int            idx, n_to;

      vt[0] = '{4'b0100, 8'h41, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b0};
      vt[1] = '{4'b0100, 8'h41, 1'b0, 1'b1, 4'b0100, 1'b1, 8'h41, 1'b0, 4'b0100, 1'b1};
      vt[2] = '{4'b0100, 8'h42, 1'b0, 1'b1, 4'b0100, 1'b1, 8'h42, 1'b0, 4'b0100, 1'b1};
      vt[3] = '{4'b0100, 8'h43, 1'b1, 1'b1, 4'b0100, 1'b1, 8'h43, 1'b1, 4'b0100, 1'b1};
      vt[4] = '{4'b0000, 8'h00, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b0};
      vt[5] = '{4'b0000, 8'h00, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b0};

      rst = 1'b1; s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b1;
      @(negedge clk);
      do_reset();
      model_on = 1;

      // ---- 1: single 3-byte packet from source 2, table driven ----
      for (int i = 0; i < 6; i++) begin
         s_tdata  = {N{8'hEE}};
         s_tdata[2*DW +: DW] = vt[i].d;
         s_tvalid = vt[i].vld;
         s_tlast  = '0;
         s_tlast[2] = vt[i].l;
         m_tready = vt[i].rdy;
         step();
         chk($sformatf("t%0d_grant", i),  sm_grant, vt[i].eg);
         chk($sformatf("t%0d_tvalid", i), sm_v, vt[i].ev);
         chk($sformatf("t%0d_tdata", i),  sm_d, vt[i].ed);
         chk($sformatf("t%0d_tlast", i),  sm_l, vt[i].el);
         chk($sformatf("t%0d_sready", i), sm_rdy, vt[i].er);
         chk($sformatf("t%0d_busy", i),   sm_busy, vt[i].eb);
         if (i == 0) begin
            chk("rst_timeout", sm_to, 1'b0);
            chk("rst_tosrc",   sm_tosrc, 2'd0);
         end
      end

      // ---- 2: all four sources stream 2-byte packets ----
      do_reset();
      for (int k = 0; k < N; k++) cnt[k] = 0;
      exp2 = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h02, 8'h03};
      dq.delete(); gq.delete(); prev_g = '0;
      for (int c = 0; c < 16; c++) begin
         for (int k = 0; k < N; k++) set_src(k, 1'b1, 8'(k*16 + cnt[k]), cnt[k][0]);
         step();
         if (sm_mhs) dq.push_back(sm_d);
         if (sm_grant != 0 && prev_g == 0) gq.push_back(int'(sm_grant));
         prev_g = sm_grant;
         if (c == 3) chk("s2_bubble", sm_grant, 4'b0000);
         for (int k = 0; k < N; k++) if (sm_acc[k]) cnt[k]++;
      end
      chk("s2_nbeats", dq.size(), 10);
      for (int i = 0; i < 10; i++) chk($sformatf("s2_beat%0d", i), (i < dq.size()) ? dq[i] : 8'hXX, exp2[i]);
      chk("s2_ngrants", gq.size(), 5);
      for (int i = 0; i < 5; i++)
         chk($sformatf("s2_grant%0d", i), (i < gq.size()) ? gq[i] : -1, 32'(1 << (i % 4)));

      // ---- 3: ready toggling during a 4-byte packet from source 1 ----
      do_reset();
      dq.delete(); lq.delete(); idx = 0; n_to = 0;
      for (int c = 0; c < 12; c++) begin
         if (idx < 4) set_src(1, 1'b1, 8'(8'hA0 + idx), (idx == 3));
         else         set_src(1, 1'b0, 8'h00, 1'b0);
         m_tready = (c % 2 == 0);
         step();
         if (sm_mhs) begin dq.push_back(sm_d); lq.push_back(sm_l); end
         if (sm_to) n_to++;
         if (sm_acc[1]) idx++;
      end
      chk("s3_nbeats", dq.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("s3_beat%0d", i), (i < dq.size()) ? dq[i] : 8'hXX, 8'(8'hA0 + i));
         chk($sformatf("s3_last%0d", i), (i < lq.size()) ? lq[i] : 1'bx, (i == 3));
      end
      chk("s3_no_timeout", n_to, 0);

      // ---- 4: source 3 stalls mid-packet, source 0 pending ----
      do_reset();
      m_tready = 1'b1;
      set_src(3, 1'b1, 8'h55, 1'b0);
      step();
      step();
      chk("s4_first_beat", sm_acc[3], 1'b1);
      set_src(3, 1'b0, 8'h00, 1'b0);
      set_src(0, 1'b1, 8'h99, 1'b1);
      for (int c = 2; c < 13; c++) begin
         step();
         gr[c] = sm_grant; to_a[c] = sm_to; r0[c] = sm_rdy[0]; ts[c] = sm_tosrc;
         if (sm_acc[0]) set_src(0, 1'b0, 8'h00, 1'b0);
      end
      for (int c = 2; c < 10; c++) begin
         chk($sformatf("s4_noto_c%0d", c), to_a[c], 1'b0);
         chk($sformatf("s4_r0_c%0d", c), r0[c], 1'b0);
      end
      chk("s4_pulse",    to_a[10], 1'b1);
      chk("s4_tosrc",    ts[10], 2'd3);
      chk("s4_idle",     gr[10], 4'b0000);
      chk("s4_pulse_end", to_a[11], 1'b0);
      chk("s4_next",     gr[11], 4'b0001);
      chk("s4_tosrc_hold", ts[12], 2'd3);

      // ---- 5: source 0 requests while source 1 is mid-packet ----
      do_reset();
      idx = 0;
      for (int c = 0; c < 7; c++) begin
         if (idx < 3) set_src(1, 1'b1, 8'(8'hB0 + idx), (idx == 2));
         else         set_src(1, 1'b0, 8'h00, 1'b0);
         if (c == 2) set_src(0, 1'b1, 8'hC0, 1'b1);
         step();
         gr[c] = sm_grant; r0[c] = sm_rdy[0];
         if (sm_acc[1]) idx++;
         if (sm_acc[0]) set_src(0, 1'b0, 8'h00, 1'b0);
      end
      for (int c = 2; c < 5; c++) chk($sformatf("s5_r0_c%0d", c), r0[c], 1'b0);
      chk("s5_hold", gr[3], 4'b0010);
      chk("s5_gap",  gr[4], 4'b0000);
      chk("s5_next", gr[5], 4'b0001);

      // ---- 6: reset during beat 2 of a 5-byte packet ----
      do_reset();
      set_src(1, 1'b1, 8'hD0, 1'b0);
      step();
      step();
      chk("s6_beat1", sm_acc[1], 1'b1);
      set_src(1, 1'b1, 8'hD1, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      set_src(0, 1'b1, 8'hE0, 1'b1);
      set_src(1, 1'b1, 8'hD2, 1'b0);
      set_src(2, 1'b1, 8'hE2, 1'b1);
      step();
      chk("s6_grant",  sm_grant, 4'b0000);
      chk("s6_tvalid", sm_v, 1'b0);
      chk("s6_tdata",  sm_d, 8'h00);
      chk("s6_tlast",  sm_l, 1'b0);
      chk("s6_sready", sm_rdy, 4'b0000);
      chk("s6_busy",   sm_busy, 1'b0);
      chk("s6_to",     sm_to, 1'b0);
      chk("s6_tosrc",  sm_tosrc, 2'd0);
      step();
      chk("s6_winner", sm_grant, 4'b0001);

      // ---- 7: randomized traffic against the model ----
      do_reset();
      for (int k = 0; k < N; k++) gap[k] = $urandom_range(0, 3);
      for (int c = 0; c < 3000; c++) begin
         m_tready = ($urandom % 4 != 0);
         step();
         for (int k = 0; k < N; k++) begin
            if (sm_acc[k]) begin
               if ($urandom % 5 == 0) begin
                  s_tvalid[k] = 1'b0;
                  gap[k] = $urandom_range(1, 12);
               end else begin
                  set_src(k, 1'b1, 8'($urandom), ($urandom % 4 == 0));
               end
            end else if (!s_tvalid[k]) begin
               if (gap[k] > 0) gap[k]--;
               else set_src(k, 1'b1, 8'($urandom), ($urandom % 4 == 0));
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
